// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: frame constants, baud selection,
// FSM state encoding and the baud divisor table.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 16;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'd0,
    BAUD_19200  = 2'd1,
    BAUD_57600  = 2'd2,
    BAUD_115200 = 2'd3
  } baud_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Clocks per 16x oversample tick, rounded to nearest: round(clk/(baud*16)).
  function automatic logic [DIV_W-1:0] baud_div(input int clk_hz, input baud_sel_e sel);
    int baud;
    int d;
    case (sel)
      BAUD_9600:   baud = 9600;
      BAUD_19200:  baud = 19200;
      BAUD_57600:  baud = 57600;
      default:     baud = 115200;
    endcase
    d = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    if (d < 1) d = 1;
    return d[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO. A pop is honoured only when non-empty;
// a push is honoured when not full, or when full and a pop happens on the same edge.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] data,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign data    = empty ? 8'h00 : mem[rd_ptr];

  // Storage array; contents are only visible through the occupancy count.
  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, per-frame baud capture and a
// receive FIFO. Read side handshake: data_o is valid while data_valid_o is
// high, and a byte is consumed on each rising edge where data_read_i and
// data_valid_o are both high.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 50_000_000,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       uart_rx_i,
  input  logic [1:0] baudrate_select_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  input  logic       data_read_i,
  output logic       data_buffer_full_o,
  output logic       frame_error_o,
  output logic       overrun_error_o,
  output logic [1:0] debug_state_o
);

  rx_state_e        state, state_n;
  logic             sync_1, sync_2, rx_prev;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] clk_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             brk_wait;
  logic             push_q;
  logic             tick, fall;
  logic             start_det, bit_sample, push_n, ferr_n, brk_set, brk_clr;
  logic             fifo_empty, fifo_full;

  assign tick          = (clk_cnt == div_q - DIV_W'(1));
  assign fall          = rx_prev & ~sync_2;
  assign debug_state_o = state;
  assign data_valid_o       = ~fifo_empty;
  assign data_buffer_full_o = fifo_full;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_1  <= 1'b1;
      sync_2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_1  <= uart_rx_i;
      sync_2  <= sync_1;
      rx_prev <= sync_2;
    end
  end

  // FSM state register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= ST_IDLE;
    else            state <= state_n;
  end

  // Next-state and per-cycle strobes. START samples at tick 8 (mid start bit);
  // DATA and STOP sample every 16 ticks after that. A bad stop bit holds STOP
  // until the line returns high so a break is not mistaken for a new start.
  always_comb begin
    state_n    = state;
    start_det  = 1'b0;
    bit_sample = 1'b0;
    push_n     = 1'b0;
    ferr_n     = 1'b0;
    brk_set    = 1'b0;
    brk_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_n   = ST_START;
          start_det = 1'b1;
        end
      end
      ST_START: begin
        if (tick && tick_cnt == 4'd7) state_n = sync_2 ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick && tick_cnt == 4'd15) begin
          bit_sample = 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (brk_wait) begin
          if (sync_2) begin
            state_n = ST_IDLE;
            brk_clr = 1'b1;
          end
        end else if (tick && tick_cnt == 4'd15) begin
          if (sync_2) begin
            push_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            ferr_n  = 1'b1;
            brk_set = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Baud capture, oversample tick counters, bit counter and shift register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_q    <= '0;
      clk_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      brk_wait <= 1'b0;
    end else begin
      if (start_det) begin
        div_q    <= baud_div(CLOCK_FREQ_HZ, baud_sel_e'(baudrate_select_i));
        clk_cnt  <= '0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != ST_IDLE) begin
        if (tick) begin
          clk_cnt  <= '0;
          tick_cnt <= (state == ST_START && tick_cnt == 4'd7) ? 4'd0 : tick_cnt + 4'd1;
        end else begin
          clk_cnt <= clk_cnt + DIV_W'(1);
        end
      end
      if (bit_sample) begin
        shift_q <= {sync_2, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (brk_set)      brk_wait <= 1'b1;
      else if (brk_clr) brk_wait <= 1'b0;
    end
  end

  // Registered push strobe and one-cycle error pulses.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      push_q          <= 1'b0;
      frame_error_o   <= 1'b0;
      overrun_error_o <= 1'b0;
    end else begin
      push_q          <= push_n;
      frame_error_o   <= ferr_n;
      overrun_error_o <= push_q & fifo_full & ~(data_read_i & ~fifo_empty);
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .push      (push_q),
    .pop       (data_read_i),
    .wdata     (shift_q),
    .data      (data_o),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: reset, false start, table of frames
// (including bad stop bits and baud changes mid-frame), FIFO fill/overrun,
// simultaneous push/pop at full, and reset in the middle of a frame.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CLK_HZ = 25_000_000;
  localparam int DEPTH  = 16;
  localparam int NVEC   = 7;

  logic       clock;
  logic       reset_n_i;
  logic       uart_rx_i;
  logic [1:0] baudrate_select_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_read_i;
  logic       data_buffer_full_o;
  logic       frame_error_o;
  logic       overrun_error_o;
  logic [1:0] debug_state_o;

  uart_receiver #(
    .CLOCK_FREQ_HZ (CLK_HZ),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clock_i            (clock),
    .reset_n_i          (reset_n_i),
    .uart_rx_i          (uart_rx_i),
    .baudrate_select_i  (baudrate_select_i),
    .data_o             (data_o),
    .data_valid_o       (data_valid_o),
    .data_read_i        (data_read_i),
    .data_buffer_full_o (data_buffer_full_o),
    .frame_error_o      (frame_error_o),
    .overrun_error_o    (overrun_error_o),
    .debug_state_o      (debug_state_o)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #(150_000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  // Error pulse monitor.
  int   ferr_cnt  = 0;
  int   ovr_cnt   = 0;
  int   ferr_long = 0;
  logic ferr_d    = 1'b0;
  always @(negedge clock) begin
    if (frame_error_o) ferr_cnt <= ferr_cnt + 1;
    if (overrun_error_o) ovr_cnt <= ovr_cnt + 1;
    if (frame_error_o && ferr_d) ferr_long <= ferr_long + 1;
    ferr_d <= frame_error_o;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [1:0] sel;
    logic [1:0] sel_after;
    logic       exp_push;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs [NVEC];

  function automatic int baud_of(input logic [1:0] s);
    case (s)
      2'd0:    return 9600;
      2'd1:    return 19200;
      2'd2:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Bit period in clocks from the nominal baud rate, rounded to nearest tick.
  function automatic int bit_clocks(input logic [1:0] s);
    real tick_r;
    tick_r = real'(CLK_HZ) / (real'(baud_of(s)) * 16.0);
    return 16 * $rtoi(tick_r + 0.5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive a frame: start bit, nbits data bits LSB first, then the stop bit
  // (only when all 8 data bits are sent). baudrate_select_i switches to
  // sel_after shortly after the start bit begins.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic [1:0] sel, input logic [1:0] sel_after,
                            input int nbits);
    int bc;
    bc = bit_clocks(sel);
    @(negedge clock);
    baudrate_select_i = sel;
    uart_rx_i = 1'b0;
    idle_clks(10);
    baudrate_select_i = sel_after;
    idle_clks(bc - 10);
    for (int i = 0; i < nbits; i++) begin
      uart_rx_i = data[i];
      idle_clks(bc);
    end
    if (nbits == 8) begin
      uart_rx_i = stop_bit;
      idle_clks(bc);
      uart_rx_i = 1'b1;
    end
  endtask

  task automatic pop_one();
    data_read_i = 1'b1;
    @(negedge clock);
    data_read_i = 1'b0;
  endtask

  int f0, o0, bc3;
  logic exp_ovr;
  logic [7:0] b;

  initial begin
    reset_n_i = 1'b1;
    uart_rx_i = 1'b1;
    baudrate_select_i = 2'd3;
    data_read_i = 1'b0;
    bc3 = bit_clocks(2'd3);

    // Vector table: fixed frames then randomized ones.
    vecs[0] = '{data: 8'hA5, stop: 1'b1, sel: 2'd3, sel_after: 2'd3, exp_push: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, sel: 2'd3, sel_after: 2'd3, exp_push: 1'b0, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'h81, stop: 1'b1, sel: 2'd3, sel_after: 2'd3, exp_push: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'(32'($urandom_range(0, 255))), stop: 1'b1, sel: 2'd2, sel_after: 2'd3,
                exp_push: 1'b1, exp_ferr: 1'b0};
    for (int i = 4; i < NVEC; i++) begin
      vecs[i].data      = 8'(32'($urandom_range(0, 255)));
      vecs[i].stop      = ($urandom_range(0, 3) != 0);
      vecs[i].sel       = 2'(32'($urandom_range(2, 3)));
      vecs[i].sel_after = 2'(32'($urandom_range(0, 3)));
      vecs[i].exp_push  = vecs[i].stop;
      vecs[i].exp_ferr  = ~vecs[i].stop;
    end

    // Asynchronous reset: outputs take reset values with no clock edge.
    idle_clks(3);
    #2 reset_n_i = 1'b0;
    #1;
    check("rst_data", 32'(data_o), 32'h00);
    check("rst_valid", 32'(data_valid_o), 32'd0);
    check("rst_full", 32'(data_buffer_full_o), 32'd0);
    check("rst_ferr", 32'(frame_error_o), 32'd0);
    check("rst_ovr", 32'(overrun_error_o), 32'd0);
    check("rst_state", 32'(debug_state_o), 32'(ST_IDLE));
    idle_clks(3);
    reset_n_i = 1'b1;
    idle_clks(5);

    // Read while empty is ignored.
    pop_one();
    idle_clks(2);
    check("empty_read_valid", 32'(data_valid_o), 32'd0);
    check("empty_read_data", 32'(data_o), 32'h00);

    // False start: line low 100 clocks then high.
    f0 = ferr_cnt;
    uart_rx_i = 1'b0;
    idle_clks(100);
    uart_rx_i = 1'b1;
    idle_clks(2 * bc3);
    check("false_start_state", 32'(debug_state_o), 32'(ST_IDLE));
    check("false_start_valid", 32'(data_valid_o), 32'd0);
    check("false_start_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Table-driven frames, each read out afterwards.
    for (int i = 0; i < NVEC; i++) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].sel, vecs[i].sel_after, 8);
      idle_clks(4);
      check($sformatf("vec%0d_valid", i), 32'(data_valid_o), 32'(vecs[i].exp_push));
      if (vecs[i].exp_push) check($sformatf("vec%0d_data", i), 32'(data_o), 32'(vecs[i].data));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - o0), 32'd0);
      if (data_valid_o) pop_one();
      idle_clks(2);
      check($sformatf("vec%0d_drained", i), 32'(data_valid_o), 32'd0);
      idle_clks(20);
    end

    // Fill: 17 bytes 0x00..0x10 with no reads.
    exp_q.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'(i);
      o0 = ovr_cnt;
      send_frame(b, 1'b1, 2'd3, 2'd3, 8);
      idle_clks(4);
      exp_ovr = (exp_q.size() >= DEPTH);
      if (!exp_ovr) exp_q.push_back(b);
      check($sformatf("fill%0d_ovr", i), 32'(ovr_cnt - o0), 32'(exp_ovr));
      check($sformatf("fill%0d_full", i), 32'(data_buffer_full_o), 32'(exp_q.size() == DEPTH));
      check($sformatf("fill%0d_head", i), 32'(data_o), 32'(exp_q[0]));
    end

    // Full FIFO: read exactly on the push cycle of byte 0x11.
    o0 = ovr_cnt;
    fork
      send_frame(8'h11, 1'b1, 2'd3, 2'd3, 8);
      begin
        int k;
        k = 0;
        while (debug_state_o != ST_STOP && k < 20 * bc3) begin
          @(negedge clock);
          k++;
        end
        while (debug_state_o == ST_STOP && k < 20 * bc3) begin
          @(negedge clock);
          k++;
        end
        check("push_cycle_found", 32'(k < 20 * bc3), 32'd1);
        data_read_i = 1'b1;
        @(negedge clock);
        data_read_i = 1'b0;
      end
    join
    idle_clks(4);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h11);
    check("pushpop_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("pushpop_full", 32'(data_buffer_full_o), 32'd1);

    // Drain and compare order.
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d", i), 32'(data_o), 32'(exp_q.pop_front()));
      pop_one();
    end
    idle_clks(2);
    check("drain_valid", 32'(data_valid_o), 32'd0);
    check("drain_full", 32'(data_buffer_full_o), 32'd0);

    // Reset mid-DATA with a byte already buffered.
    send_frame(8'hC3, 1'b1, 2'd3, 2'd3, 8);
    idle_clks(4);
    check("pre_reset_valid", 32'(data_valid_o), 32'd1);
    send_frame(8'h77, 1'b1, 2'd3, 2'd3, 3);
    #2 reset_n_i = 1'b0;
    #1;
    check("midrst_valid", 32'(data_valid_o), 32'd0);
    check("midrst_data", 32'(data_o), 32'h00);
    check("midrst_state", 32'(debug_state_o), 32'(ST_IDLE));
    uart_rx_i = 1'b1;
    idle_clks(5);
    reset_n_i = 1'b1;
    idle_clks(bc3);
    f0 = ferr_cnt;
    send_frame(8'h5A, 1'b1, 2'd3, 2'd3, 8);
    idle_clks(4);
    check("post_rst_valid", 32'(data_valid_o), 32'd1);
    check("post_rst_data", 32'(data_o), 32'h5A);
    check("post_rst_ferr", 32'(ferr_cnt - f0), 32'd0);
    pop_one();

    idle_clks(4);
    check("ferr_single_pulse", 32'(ferr_long), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: CLOCK_FREQ_HZ, 50_000_000, system clock frequency used for divisor computation.
REQ-002 Parameter: FIFO_DEPTH, 16, receive buffer depth in bytes; power of two, minimum 4.
REQ-003 Port: clock_i  in  1  single system clock; all logic on rising edge.
REQ-004 Port: reset_n_i  in  1  asynchronous, active-low reset.
REQ-005 Port: uart_rx_i  in  1  serial line, idle high, asynchronous to clock_i.
REQ-006 Port: baudrate_select_i  in  2  baud select: 0=9600, 1=19200, 2=57600, 3=115200.
REQ-007 Port: data_o  out  8  head byte of receive FIFO, first-word-fall-through.
REQ-008 Port: data_valid_o  out  1  high while the FIFO is non-empty.
REQ-009 Port: data_read_i  in  1  pops the head byte when data_valid_o is high.
REQ-010 Port: data_buffer_full_o  out  1  high when the FIFO holds FIFO_DEPTH bytes.
REQ-011 Port: frame_error_o  out  1  one-cycle pulse on a bad stop bit.
REQ-012 Port: overrun_error_o  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014 uart_rx_i SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 The baud tick generator SHALL produce one 16x-oversample tick every DIV[baudrate_select] clocks, where DIV = round(CLOCK_FREQ_HZ/(baud*16)).
REQ-016 baudrate_select_i SHALL be captured on start detection and held constant for the whole frame.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-018 IDLE->START SHALL occur on a synchronized high-to-low transition; the tick counter resets at that point.
REQ-019 START SHALL resample the line at tick 8: if 0, go to DATA; if 1 (false start), go to IDLE with no output.
REQ-020 DATA SHALL sample each bit 16 ticks after the previous sample, shifting into bit position 0..7 in order, and go to STOP after the 8th bit.
REQ-021 STOP SHALL sample 16 ticks after bit 7: if 1, push the byte; if 0, pulse frame_error_o, discard the byte, and return to IDLE only after the line reads 1.
REQ-022 A push SHALL update the FIFO on the clock after the stop sample; data_valid_o rises on that same edge when the FIFO was empty.
REQ-023 A pop SHALL occur when data_read_i and data_valid_o are both high; data_o shows the next byte on the following cycle.
REQ-024 data_read_i while the FIFO is empty SHALL be ignored, with no state change and no error.
REQ-025 A push with the FIFO full and no pop SHALL drop the new byte, pulse overrun_error_o, and leave the FIFO contents unchanged.
REQ-026 A simultaneous push and pop SHALL both succeed at any fill level, including full, with no overrun; occupancy is unchanged.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width SHALL be clog2(FIFO_DEPTH)+1.
REQ-028 Error pulses SHALL NOT affect FIFO contents or data_valid_o.

Reset
REQ-029 Asserting reset_n_i low SHALL, without waiting for a clock, set: FSM=IDLE, synchronizer flops=1, tick/bit counters=0, FIFO empty, data_o=0x00, data_valid_o=0, data_buffer_full_o=0, frame_error_o=0, overrun_error_o=0.
REQ-030 Reset mid-frame SHALL abandon the partial byte; reception resumes on the next falling edge after reset is released.

Structure
REQ-031 A shared package uart_pkg SHALL hold the baud-select enum, the DIV table function, the FSM state typedef, and the frame constants (DATA_BITS=8, OVERSAMPLE=16).
REQ-032 The FIFO SHALL be a sub-module uart_rx_fifo exposing push, pop, data, empty, and full.

Verification
REQ-033 Baud 3, CLOCK 50 MHz (DIV=27, bit=432 clocks): send 0xA5 -> data_o=0xA5 and data_valid_o=1 within one bit-time after the stop mid-sample; no errors.
REQ-034 Line low for 100 clocks then high at baud 3 -> no push, no error, FSM back in IDLE.
REQ-035 Send 0x3C with the stop bit forced to 0 -> frame_error_o is a single pulse, the FIFO stays empty, and the next valid 0x81 is received correctly.
REQ-036 Send 17 bytes 0x00..0x10 with no reads (depth 16) -> data_buffer_full_o=1 after the 16th byte, one overrun pulse on the 17th, and reads return 0x00..0x0F.
REQ-037 With the FIFO full, issue a read on the exact push cycle -> no overrun and occupancy stays 16; also drop reset_n_i mid-DATA -> outputs reach reset values asynchronously and the next byte 0x5A is received.
